// File: rtl/rob_pkg.sv
// Shared constants and types for the reorder buffer: default geometry,
// tag-width helper and the per-entry record layout.
package rob_pkg;

    localparam int ROB_DEPTH     = 16;
    localparam int ROB_XLEN      = 32;
    localparam int ROB_RIDX_W    = 5;
    localparam int ROB_CDB_PORTS = 2;

    function automatic int tag_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    localparam int ROB_TAG_W = tag_w(ROB_DEPTH);

    typedef struct packed {
        logic                  busy;
        logic                  done;
        logic [ROB_RIDX_W-1:0] rd;
        logic [ROB_XLEN-1:0]   val;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buf_if.sv
// Decode/CDB/commit bundle of the reorder buffer; master = decode/execute side,
// slave = the buffer itself.
// Handshake: an allocation is taken on a rising clk edge where alloc_valid and
// alloc_ready are both high; alloc_ready never depends on alloc_valid.
interface reorder_buf_if
    import rob_pkg::*;
#(
    parameter int DEPTH     = ROB_DEPTH,
    parameter int XLEN      = ROB_XLEN,
    parameter int RIDX_W    = ROB_RIDX_W,
    parameter int CDB_PORTS = ROB_CDB_PORTS
);
    localparam int TAG_W = tag_w(DEPTH);

    logic                       alloc_valid;
    logic [RIDX_W-1:0]          alloc_rd;
    logic                       alloc_done;
    logic [XLEN-1:0]            alloc_val;
    logic                       alloc_ready;
    logic [TAG_W-1:0]           alloc_tag;
    logic [CDB_PORTS-1:0]       cdb_valid;
    logic [CDB_PORTS*TAG_W-1:0] cdb_tag;
    logic [CDB_PORTS*XLEN-1:0]  cdb_val;
    logic [TAG_W-1:0]           qry_tag;
    logic                       qry_ready;
    logic [XLEN-1:0]            qry_val;
    logic                       commit_valid;
    logic [RIDX_W-1:0]          commit_rd;
    logic [XLEN-1:0]            commit_val;
    logic [TAG_W-1:0]           commit_tag;

    modport master (
        output alloc_valid, alloc_rd, alloc_done, alloc_val,
        output cdb_valid, cdb_tag, cdb_val, qry_tag,
        input  alloc_ready, alloc_tag, qry_ready, qry_val,
        input  commit_valid, commit_rd, commit_val, commit_tag
    );

    modport slave (
        input  alloc_valid, alloc_rd, alloc_done, alloc_val,
        input  cdb_valid, cdb_tag, cdb_val, qry_tag,
        output alloc_ready, alloc_tag, qry_ready, qry_val,
        output commit_valid, commit_rd, commit_val, commit_tag
    );

endinterface

// File: rtl/rob_cdb_sel.sv
// Priority select across CDB ports for one tag: reports whether any valid
// port targets match_tag and returns the value of the highest such port.
module rob_cdb_sel #(
    parameter int TAG_W     = 4,
    parameter int XLEN      = 32,
    parameter int CDB_PORTS = 2
) (
    input  logic [TAG_W-1:0]           match_tag,
    input  logic [CDB_PORTS-1:0]       cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
    input  logic [CDB_PORTS*XLEN-1:0]  cdb_val,
    output logic                       hit,
    output logic [XLEN-1:0]            val
);

    // Ascending scan: later (higher-numbered) ports overwrite earlier ones.
    always_comb begin
        hit = 1'b0;
        val = '0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == match_tag)) begin
                hit = 1'b1;
                val = cdb_val[p*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/reorder_buf.sv
// In-order retire reorder buffer with multi-port CDB write-back and flush.
// Optional macro REORDER_BUF_QRY_BYPASS_EN forwards same-cycle CDB data to the operand query.
module reorder_buf
    import rob_pkg::*;
#(
    parameter int DEPTH     = ROB_DEPTH,
    parameter int XLEN      = ROB_XLEN,
    parameter int RIDX_W    = ROB_RIDX_W,
    parameter int CDB_PORTS = ROB_CDB_PORTS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    flush,
    output logic                    full,
    output logic                    empty,
    output logic [tag_w(DEPTH)-1:0] dbg_head,
    output logic [tag_w(DEPTH)-1:0] dbg_tail,
    output logic [tag_w(DEPTH):0]   dbg_count,
    reorder_buf_if.slave            rob
);

    localparam int TAG_W = tag_w(DEPTH);
    localparam int CNT_W = TAG_W + 1;

    logic [DEPTH-1:0]  busy_q, busy_d, done_q, done_d;
    logic [RIDX_W-1:0] rd_q   [DEPTH];
    logic [RIDX_W-1:0] rd_d   [DEPTH];
    logic [XLEN-1:0]   val_q  [DEPTH];
    logic [XLEN-1:0]   val_d  [DEPTH];
    logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              commit_valid_q, commit_valid_d;
    logic [RIDX_W-1:0] commit_rd_q, commit_rd_d;
    logic [XLEN-1:0]   commit_val_q, commit_val_d;
    logic [TAG_W-1:0]  commit_tag_q, commit_tag_d;

    logic [DEPTH-1:0]  cdb_hit;
    logic [XLEN-1:0]   cdb_hit_val [DEPTH];
    logic              do_alloc, do_commit;

    for (genvar i = 0; i < DEPTH; i++) begin : g_sel
        rob_cdb_sel #(.TAG_W(TAG_W), .XLEN(XLEN), .CDB_PORTS(CDB_PORTS)) u_sel (
            .match_tag (TAG_W'(i)),
            .cdb_valid (rob.cdb_valid),
            .cdb_tag   (rob.cdb_tag),
            .cdb_val   (rob.cdb_val),
            .hit       (cdb_hit[i]),
            .val       (cdb_hit_val[i])
        );
    end

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign dbg_head  = head_q;
    assign dbg_tail  = tail_q;
    assign dbg_count = count_q;

    // Registered full gates allocation, so a same-cycle retire never frees a slot early.
    assign rob.alloc_ready = !full;
    assign rob.alloc_tag   = tail_q;
    assign do_alloc  = rdy && !flush && rob.alloc_valid && !full;
    assign do_commit = rdy && !flush && !empty && done_q[head_q];

    assign rob.commit_valid = commit_valid_q;
    assign rob.commit_rd    = commit_rd_q;
    assign rob.commit_val   = commit_val_q;
    assign rob.commit_tag   = commit_tag_q;

`ifdef REORDER_BUF_QRY_BYPASS_EN
    logic            byp_hit;
    logic [XLEN-1:0] byp_val;

    rob_cdb_sel #(.TAG_W(TAG_W), .XLEN(XLEN), .CDB_PORTS(CDB_PORTS)) u_qry_sel (
        .match_tag (rob.qry_tag),
        .cdb_valid (rob.cdb_valid),
        .cdb_tag   (rob.cdb_tag),
        .cdb_val   (rob.cdb_val),
        .hit       (byp_hit),
        .val       (byp_val)
    );

    assign rob.qry_ready = byp_hit || (busy_q[rob.qry_tag] && done_q[rob.qry_tag]);
    assign rob.qry_val   = byp_hit ? byp_val : val_q[rob.qry_tag];
`else
    assign rob.qry_ready = busy_q[rob.qry_tag] && done_q[rob.qry_tag];
    assign rob.qry_val   = val_q[rob.qry_tag];
`endif

    always_comb begin
        busy_d         = busy_q;
        done_d         = done_q;
        rd_d           = rd_q;
        val_d          = val_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_valid_d = 1'b0;
        commit_rd_d    = commit_rd_q;
        commit_val_d   = commit_val_q;
        commit_tag_d   = commit_tag_q;
        if (rdy && flush) begin
            busy_d  = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (rdy) begin
            // A write to the slot being reallocated this cycle belongs to a stale producer.
            for (int i = 0; i < DEPTH; i++) begin
                if (cdb_hit[i] && busy_q[i] && !(do_alloc && (tail_q == TAG_W'(i)))) begin
                    done_d[i] = 1'b1;
                    val_d[i]  = cdb_hit_val[i];
                end
            end
            if (do_alloc) begin
                busy_d[tail_q] = 1'b1;
                done_d[tail_q] = rob.alloc_done;
                rd_d[tail_q]   = rob.alloc_rd;
                val_d[tail_q]  = rob.alloc_val;
                tail_d         = tail_q + 1'b1;
            end
            if (do_commit) begin
                commit_valid_d = 1'b1;
                commit_rd_d    = rd_q[head_q];
                commit_val_d   = val_q[head_q];
                commit_tag_d   = head_q;
                busy_d[head_q] = 1'b0;
                done_d[head_q] = 1'b0;
                head_d         = head_q + 1'b1;
            end
            case ({do_alloc, do_commit})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q         <= '0;
            done_q         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]  <= '0;
                val_q[i] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_val_q   <= '0;
            commit_tag_q   <= '0;
        end else begin
            busy_q         <= busy_d;
            done_q         <= done_d;
            rd_q           <= rd_d;
            val_q          <= val_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_rd_q    <= commit_rd_d;
            commit_val_q   <= commit_val_d;
            commit_tag_q   <= commit_tag_d;
        end
    end

endmodule

// File: tb/tb_reorder_buf.sv
// Directed bench for reorder_buf (DEPTH=16, two CDB ports); expected values
// follow REORDER_BUF_QRY_BYPASS_EN when it is defined for the build.
module tb_reorder_buf;
    import rob_pkg::*;

    localparam int EXP_W = $bits(rob_entry_t);

    logic       clk;
    logic       rst;
    logic       rdy;
    logic       flush;
    logic       full;
    logic       empty;
    logic [3:0] head;
    logic [3:0] tail;
    logic [4:0] count;

    int total = 0;
    int bad   = 0;
    logic [EXP_W-1:0] exp_q[$];

    reorder_buf_if #(.DEPTH(16), .XLEN(32), .RIDX_W(5), .CDB_PORTS(2)) rob ();

    reorder_buf #(.DEPTH(16), .XLEN(32), .RIDX_W(5), .CDB_PORTS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (flush),
        .full      (full),
        .empty     (empty),
        .dbg_head  (head),
        .dbg_tail  (tail),
        .dbg_count (count),
        .rob       (rob)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // driver tasks
    task automatic idle();
        rdy             = 1'b1;
        flush           = 1'b0;
        rob.alloc_valid = 1'b0;
        rob.alloc_rd    = '0;
        rob.alloc_done  = 1'b0;
        rob.alloc_val   = '0;
        rob.cdb_valid   = '0;
        rob.cdb_tag     = '0;
        rob.cdb_val     = '0;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic done, input logic [31:0] v);
        rob.alloc_valid = 1'b1;
        rob.alloc_rd    = rd;
        rob.alloc_done  = done;
        rob.alloc_val   = v;
    endtask

    task automatic cdb_set(input int p, input logic [3:0] tag, input logic [31:0] v);
        rob.cdb_valid[p]       = 1'b1;
        rob.cdb_tag[p*4 +: 4]  = tag;
        rob.cdb_val[p*32 +: 32] = v;
    endtask

    task automatic expect_commit(input logic [4:0] rd, input logic [31:0] v);
        rob_entry_t e;
        e = '{busy: 1'b1, done: 1'b1, rd: rd, val: v};
        exp_q.push_back(EXP_W'(e));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: every commit pulse must match the oldest expected retire
    always @(posedge clk) begin
        #1;
        if (rob.commit_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_commit rd=%0d val=%0h tag=%0d", rob.commit_rd, rob.commit_val, rob.commit_tag);
            end else begin
                rob_entry_t e;
                e = rob_entry_t'(exp_q.pop_front());
                chk("commit_rd", 64'(rob.commit_rd), 64'(e.rd));
                chk("commit_val", 64'(rob.commit_val), 64'(e.val));
            end
        end
    end

    typedef struct {
        logic       av;
        logic [4:0] rd;
        logic [3:0] exp_tag;
        logic       exp_ready;
        logic [4:0] exp_count;
        logic       exp_full;
    } vec_t;

    vec_t vecs[17];
    logic exp_byp;

    initial begin
`ifdef REORDER_BUF_QRY_BYPASS_EN
        exp_byp = 1'b1;
`else
        exp_byp = 1'b0;
`endif
        // Fill: tags 0..15 accepted; the 17th request sees a full buffer.
        for (int i = 0; i < 16; i++)
            vecs[i] = '{av: 1'b1, rd: 5'(i), exp_tag: 4'(i), exp_ready: 1'b1,
                        exp_count: 5'(i + 1), exp_full: (i == 15)};
        vecs[16] = '{av: 1'b1, rd: 5'd20, exp_tag: 4'd0, exp_ready: 1'b0,
                     exp_count: 5'd16, exp_full: 1'b1};

        rst = 1'b0;
        idle();
        rob.qry_tag = '0;
        #2;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_alloc_ready", 64'(rob.alloc_ready), 64'd1);
        chk("rst_commit_valid", 64'(rob.commit_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_commit_payload", 64'({rob.commit_rd, rob.commit_val}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 17; v++) begin
            @(negedge clk);
            idle();
            if (vecs[v].av) alloc(vecs[v].rd, 1'b0, 32'h0);
            #1;
            chk($sformatf("fill_tag[%0d]", v), 64'(rob.alloc_tag), 64'(vecs[v].exp_tag));
            chk($sformatf("fill_ready[%0d]", v), 64'(rob.alloc_ready), 64'(vecs[v].exp_ready));
            tick();
            chk($sformatf("fill_count[%0d]", v), 64'(count), 64'(vecs[v].exp_count));
            chk($sformatf("fill_full[%0d]", v), 64'(full), 64'(vecs[v].exp_full));
        end

        // Full buffer, head completes, allocation requested during the retire.
        @(negedge clk); idle(); cdb_set(0, 4'd0, 32'hA0);
        tick();
        @(negedge clk); idle(); alloc(5'd9, 1'b0, 32'h0);
        expect_commit(5'd0, 32'hA0);
        #1;
        chk("full_commit_ready", 64'(rob.alloc_ready), 64'd0);
        tick();
        chk("full_commit_count", 64'(count), 64'd15);
        chk("full_commit_tail", 64'(tail), 64'd0);
        chk("full_commit_head", 64'(head), 64'd1);
        @(negedge clk); #1;
        chk("next_ready", 64'(rob.alloc_ready), 64'd1);
        chk("next_tag_wrap", 64'(rob.alloc_tag), 64'd0);
        tick();
        chk("next_count", 64'(count), 64'd16);
        chk("next_tail", 64'(tail), 64'd1);
        @(negedge clk); idle(); flush = 1'b1;
        tick();
        chk("flush1_empty", 64'(empty), 64'd1);

        // Out-of-order completion, in-order retire.
        @(negedge clk); idle(); alloc(5'd3, 1'b0, 32'h0); #1;
        chk("ooo_tag0", 64'(rob.alloc_tag), 64'd0);
        tick();
        @(negedge clk); idle(); alloc(5'd4, 1'b0, 32'h0); #1;
        chk("ooo_tag1", 64'(rob.alloc_tag), 64'd1);
        tick();
        @(negedge clk); idle(); cdb_set(0, 4'd1, 32'hBB);
        tick();
        chk("ooo_no_commit_tail_done", 64'(rob.commit_valid), 64'd0);
        @(negedge clk); idle(); cdb_set(0, 4'd0, 32'hAA);
        expect_commit(5'd3, 32'hAA);
        expect_commit(5'd4, 32'hBB);
        tick();
        chk("ooo_latency", 64'(rob.commit_valid), 64'd0);
        @(negedge clk); idle();
        tick();
        chk("ooo_c0_valid", 64'(rob.commit_valid), 64'd1);
        chk("ooo_c0_tag", 64'(rob.commit_tag), 64'd0);
        tick();
        chk("ooo_c1_valid", 64'(rob.commit_valid), 64'd1);
        chk("ooo_c1_tag", 64'(rob.commit_tag), 64'd1);
        tick();
        chk("ooo_drop", 64'(rob.commit_valid), 64'd0);
        chk("ooo_empty", 64'(empty), 64'd1);

        // Two ports hit tag 2 together: port 1 wins.
        @(negedge clk); idle(); alloc(5'd7, 1'b0, 32'h0);
        tick();
        @(negedge clk); idle(); rob.qry_tag = 4'd2; #1;
        chk("prio_qry_before", 64'(rob.qry_ready), 64'd0);
        cdb_set(0, 4'd2, 32'h11);
        cdb_set(1, 4'd2, 32'h22);
        expect_commit(5'd7, 32'h22);
        tick();
        chk("prio_qry_ready", 64'(rob.qry_ready), 64'd1);
        chk("prio_qry_val", 64'(rob.qry_val), 64'h22);
        @(negedge clk); idle();
        tick();
        chk("prio_commit_tag", 64'(rob.commit_tag), 64'd2);

        // Query bypass on tag 5.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); alloc(5'(8 + i), 1'b0, 32'h0);
            tick();
        end
        @(negedge clk); idle(); rob.qry_tag = 4'd5; cdb_set(0, 4'd5, 32'h55); #1;
        chk("byp_qry_ready", 64'(rob.qry_ready), 64'(exp_byp));
        if (exp_byp) chk("byp_qry_val", 64'(rob.qry_val), 64'h55);
        tick();
        @(negedge clk); idle(); #1;
        chk("byp_stored_ready", 64'(rob.qry_ready), 64'd1);
        chk("byp_stored_val", 64'(rob.qry_val), 64'h55);

        // Flush with five in flight beats a same-cycle alloc and CDB write.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); idle(); alloc(5'(11 + i), 1'b0, 32'h0);
            tick();
        end
        chk("flush_pre_count", 64'(count), 64'd5);
        @(negedge clk); idle(); flush = 1'b1; alloc(5'd13, 1'b1, 32'h13); cdb_set(1, 4'd3, 32'h33);
        tick();
        chk("flush_empty", 64'(empty), 64'd1);
        chk("flush_head", 64'(head), 64'd0);
        chk("flush_tail", 64'(tail), 64'd0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_no_commit", 64'(rob.commit_valid), 64'd0);
        @(negedge clk); idle();
        tick();
        chk("flush_no_commit2", 64'(rob.commit_valid), 64'd0);

        // Writes to idle entries and to the slot being allocated are dropped.
        @(negedge clk); idle(); cdb_set(0, 4'd4, 32'h44);
        tick();
        @(negedge clk); idle(); rob.qry_tag = 4'd4; #1;
        chk("idle_write_ignored", 64'(rob.qry_ready), 64'd0);
        alloc(5'd14, 1'b0, 32'h0); cdb_set(0, 4'd0, 32'h99);
        tick();
        @(negedge clk); idle(); rob.qry_tag = 4'd0; #1;
        chk("alloc_write_ignored", 64'(rob.qry_ready), 64'd0);

        // rdy low freezes everything.
        rdy = 1'b0; alloc(5'd15, 1'b0, 32'h0); cdb_set(0, 4'd0, 32'h5A);
        tick();
        chk("stall_count", 64'(count), 64'd1);
        chk("stall_tail", 64'(tail), 64'd1);
        @(negedge clk); idle(); rob.qry_tag = 4'd0; #1;
        chk("stall_write_ignored", 64'(rob.qry_ready), 64'd0);
        cdb_set(0, 4'd0, 32'h5A);
        expect_commit(5'd14, 32'h5A);
        tick();
        @(negedge clk); idle(); alloc(5'd16, 1'b1, 32'h77);
        expect_commit(5'd16, 32'h77);
        tick();
        chk("stall_c0_valid", 64'(rob.commit_valid), 64'd1);
        chk("stall_c0_tag", 64'(rob.commit_tag), 64'd0);
        @(negedge clk); idle(); rdy = 1'b0;
        tick();
        chk("stall_commit_drop", 64'(rob.commit_valid), 64'd0);
        chk("stall_hold_count", 64'(count), 64'd1);
        @(negedge clk); idle();
        tick();
        chk("stall_c1_valid", 64'(rob.commit_valid), 64'd1);
        chk("stall_c1_tag", 64'(rob.commit_tag), 64'd1);
        chk("stall_empty", 64'(empty), 64'd1);

        // Reset mid-operation discards a ready-to-retire entry.
        @(negedge clk); idle(); alloc(5'd2, 1'b1, 32'hEE);
        tick();
        @(negedge clk); idle(); rst = 1'b0; #1;
        chk("mid_rst_empty", 64'(empty), 64'd1);
        chk("mid_rst_head", 64'(head), 64'd0);
        chk("mid_rst_tail", 64'(tail), 64'd0);
        chk("mid_rst_commit_tag", 64'(rob.commit_tag), 64'd0);
        tick();
        chk("mid_rst_no_commit", 64'(rob.commit_valid), 64'd0);
        @(negedge clk); rst = 1'b1;
        tick();
        chk("post_rst_empty", 64'(empty), 64'd1);
        chk("post_rst_no_commit", 64'(rob.commit_valid), 64'd0);

        // final report
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reorder_buf.md
REORDER_BUF -- requirements
Module: reorder_buf

Interface
REQ-001 Parameter DEPTH, 16, entry count; power of two, 4..64.
REQ-002 Parameter XLEN, 32, result value width.
REQ-003 Parameter RIDX_W, 5, architectural register index width.
REQ-004 Parameter CDB_PORTS, 2, number of result write-back ports, 1..4.
REQ-005 Localparam TAG_W = clog2(DEPTH); CNT_W = TAG_W+1.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 rdy  in  1  global enable; when low, all state holds.
REQ-009 alloc_valid  in  1  decode requests one entry.
REQ-010 alloc_rd  in  RIDX_W  destination register of the new entry.
REQ-011 alloc_done  in  1  entry is complete at issue (no execution needed).
REQ-012 alloc_val  in  XLEN  value used when alloc_done=1.
REQ-013 alloc_ready  out  1  equals !full.
REQ-014 alloc_tag  out  TAG_W  tail index given to the current request.
REQ-015 cdb_valid  in  CDB_PORTS  per-port write-back strobe.
REQ-016 cdb_tag  in  CDB_PORTS*TAG_W  packed per-port tags, port 0 in the LSBs.
REQ-017 cdb_val  in  CDB_PORTS*XLEN  packed per-port values.
REQ-018 qry_tag  in  TAG_W  operand lookup tag from decode.
REQ-019 qry_ready, qry_val  out  1, XLEN  combinational readiness and value of entry qry_tag.
REQ-020 commit_valid  out  1  registered one-cycle pulse per retired entry.
REQ-021 commit_rd, commit_val, commit_tag  out  RIDX_W, XLEN, TAG_W  registered retire payload.
REQ-022 flush  in  1  discard all in-flight entries.
REQ-023 full, empty  out  1  occupancy flags, derived from count.

Function
REQ-024 Each entry SHALL hold: busy, done, rd, val; head/tail TAG_W pointers; count CNT_W.
REQ-025 Allocate SHALL occur when alloc_valid && alloc_ready && rdy: write entry[tail] with busy=1, done=alloc_done, rd, val; increment tail modulo DEPTH; alloc_tag = tail before the increment.
REQ-026 Commit SHALL occur when rdy && !empty && entry[head].done: register payload, pulse commit_valid for one cycle, clear busy, increment head modulo DEPTH.
REQ-027 Simultaneous allocate and commit SHALL leave count unchanged; allocate alone adds 1, commit alone subtracts 1.
REQ-028 alloc_ready SHALL use the registered full flag; a commit in the same cycle does not make a full buffer accept an allocation.
REQ-029 A CDB write SHALL set done=1 and val on entry[tag] only when that entry is busy and not being allocated that cycle; other writes are ignored.
REQ-030 When two CDB ports target the same tag in the same cycle, the highest-numbered port SHALL win.
REQ-031 A CDB write to the head SHALL make the head commit no earlier than the next cycle; write-to-commit latency is 1 cycle.
REQ-032 flush SHALL take priority over allocate, commit, and CDB writes: clear busy/done, set head=tail=count=0, commit_valid=0 next cycle.
REQ-033 Pointer wrap from DEPTH-1 to 0 SHALL not disturb full/empty; full iff count==DEPTH; empty iff count==0.
REQ-034 When rdy=0: no allocate, commit, CDB write, or flush; commit_valid SHALL drop to 0.

Reset
REQ-035 rst low SHALL immediately clear all busy/done bits, head, tail, count, commit_valid, commit_rd, commit_val, and commit_tag to 0; empty=1, full=0, alloc_ready=1.
REQ-036 A reset asserted mid-operation SHALL discard in-flight entries with no commit pulse.

Configuration
REQ-037 Macro REORDER_BUF_QRY_BYPASS_EN defined: a query whose tag matches a valid CDB write in the same cycle SHALL return qry_ready=1 and that port's value, with highest port winning.
REQ-038 Macro undefined: query reflects only stored entry state; same-cycle CDB data is visible from the next cycle.

Structure
REQ-039 Shared package rob_pkg SHALL hold the default DEPTH/XLEN/RIDX_W/CDB_PORTS constants, the entry record typedef, and the TAG_W computation.
REQ-040 Sub-module rob_cdb_sel SHALL perform per-entry priority selection across CDB ports (hit flag and value); one instance per entry.

Verification
REQ-041 Reset, then allocate 16 entries (DEPTH=16) -> full=1 and alloc_ready=0 after 16th; alloc_tag runs 0..15.
REQ-042 Allocate rd=3 (tag 0), rd=4 (tag 1); CDB writes tag 1 val 0xBB, then tag 0 val 0xAA -> commits in order: rd 3/0xAA, then rd 4/0xBB, one cycle apart.
REQ-043 Ports 0 and 1 both write tag 2 (0x11, 0x22) in the same cycle -> stored val 0x22.
REQ-044 Full buffer with done head, alloc_valid=1 -> commit occurs, no allocation that cycle, count=15, and allocation is accepted next cycle.
REQ-045 Five entries in flight with flush=1 and CDB write together -> empty=1 next cycle, head=tail=0, and no commit_valid.
REQ-046 With bypass enabled, qry_tag=5 and CDB write tag 5 val 0x55 in the same cycle -> qry_ready=1, qry_val=0x55 combinationally; with bypass disabled, qry_ready=0 that cycle.
